led_ctrl: RTL and testbench
===========================

# led_ctrl

Memory-mapped multi-channel LED indicator controller on the CPU peripheral bus, sitting behind the address decoder like the other chip-select peripherals. Each of N_LEDS channels is independently set off, on, free-running blink, or counted burst (blink K times, then self-clear to off). A shared prescaler supplies the blink time base. Channel and burst registers can be read back.

## Interface
- N_LEDS, 4: number of LED channels, 1..8.
- PRESC, 25000: clk cycles per base tick, at least 2.
- clk  in  1  system clock; all state updates on the falling edge.
- rst  in  1  asynchronous, active-high reset.
- addr  in  4  register address.
- cs  in  1  chip select.
- rd  in  1  read strobe.
- wr  in  1  write strobe.
- d_in  in  8  write data.
- d_out  out  8  read data; 0 when not (cs & rd).
- led  out  N_LEDS  LED drive, 1 = lit.

## Operation
- Register map, channel c < N_LEDS:
  - 0x0+c CTRL[c]: bits[1:0] mode (0 off, 1 on, 2 blink, 3 burst); bits[7:2] HP, the half-period in base ticks. HP=0 behaves as 1.
  - 0x8+c CNT[c]: remaining burst blinks, 8 bit.
  - 0xF: write is a global command. Bit0 = all off: every mode goes to 0. Bit1 = resync: prescaler and all phase counters clear, and every blink/burst LED goes lit. Both bits set: all off wins. A read of 0xF returns STATUS, with bit c = 1 while channel c is in blink or burst mode.
- Addresses with c >= N_LEDS, and any address not listed above: writes are ignored and reads return 0.
- A write occurs on the falling edge when cs & wr are high. Reads are combinational: d_out = register at addr when cs & rd are high, else 0.
- Prescaler: free-running counter 0..PRESC-1. It asserts a one-cycle internal tick when the count equals PRESC-1, then wraps to 0.
- Per channel: a 6-bit phase counter and the led bit.
- A CTRL[c] write clears phase[c] and loads led[c]:
  - mode 0: led = 0.
  - mode 1: led = 1.
  - mode 2 or 3: led = 1.
  - mode 3 with CNT[c] = 0: mode is forced to 0 and led = 0.
- On a tick with mode 2 or 3: if phase+1 == max(HP,1), phase clears and led toggles; otherwise phase increments.
- In mode 3, each 1->0 toggle decrements CNT. When the decrement reaches 0, mode self-clears to 0 on the same edge. HP is kept, the led stays 0, and CTRL reads back with mode 0.
- A CNT write in mode 3 takes effect at once for subsequent decrements. Writing CNT = 0 while in mode 3 makes the channel finish after the next 1->0 toggle, with no further count.
- Modes 0 and 1 ignore ticks; phase holds at 0.

## Timing
- Reset values: led = 0, all CTRL = 0, all CNT = 0, prescaler = 0, phases = 0. d_out follows the read rule, so it is 0 with no read active.
- Reset asserted mid-blink or mid-burst: all of the above clear immediately, without waiting for a clock edge.
- Write-to-led latency: led changes on the same falling edge that captures the write.
- The first toggle after entering blink lands on the max(HP,1)-th tick after the write. That is between (max(HP,1)-1)*PRESC+1 and max(HP,1)*PRESC cycles after the write, because the prescaler is not restarted by channel writes.
- After resync, toggles land exactly max(HP,1)*PRESC cycles apart, starting from the resync edge.
- CTRL write and tick on the same edge: the write wins (phase = 0, led loaded, no toggle).
- CNT write and decrement on the same edge: the written value wins.
- Global command and channel tick on the same edge: the command wins.
- A burst of K produces exactly K lit pulses, each HP ticks long with HP-tick gaps. The channel is off after the K-th falling toggle.

## Test plan
All scenarios use PRESC=4 and N_LEDS=4.
- Reset mid-blink: set CTRL[0]=0x06 (HP=1, blink), run 10 cycles, pulse rst -> led = 0000 immediately, CTRL[0] reads 0x00.
- On/off: write CTRL[1]=0x01, then CTRL[1]=0x00 -> led[1] goes 1 then 0, each on its write edge; led[0], led[2] and led[3] stay 0.
- Blink period: write 0xF=0x02 (resync), then CTRL[2]=0x0A (HP=2, blink) -> led[2] toggles every 8 cycles. STATUS reads 0x04.
- Burst: write CNT[3]=3, then CTRL[3]=0x07 (HP=1) -> exactly 3 high pulses of 4 cycles. Afterwards CTRL[3] reads 0x04, CNT[3] reads 0, and STATUS bit3 = 0.
- Boundaries:
  - CTRL write colliding with a tick: no toggle, phase restarts.
  - Burst entered with CNT=0: led = 0, mode reads 0.
  - Writes to 0x4 and 0xC: ignored; reads of them return 0.
- Global all-off during two active blinks -> both leds 0 on that edge, STATUS = 0x00.

Source files
------------

// File: rtl/led_ctrl_if.sv
// led_ctrl_if: chip-select peripheral bus between the CPU side and led_ctrl.
interface led_ctrl_if;
    logic [3:0] addr;
    logic       cs;
    logic       rd;
    logic       wr;
    logic [7:0] d_in;
    logic [7:0] d_out;

    modport master (output addr, cs, rd, wr, d_in, input d_out);
    modport slave  (input addr, cs, rd, wr, d_in, output d_out);
endinterface

// File: rtl/led_ctrl.sv
// led_ctrl: memory-mapped multi-channel LED controller (off / on / blink / counted burst).
// All state advances on the falling clock edge; reads are combinational.
module led_ctrl #(
    parameter int N_LEDS = 4,
    parameter int PRESC  = 25000
) (
    input  logic              clk,
    input  logic              rst,
    led_ctrl_if.slave         bus,
    output logic [N_LEDS-1:0] led
);

    localparam int PW = (PRESC > 2) ? $clog2(PRESC) : 1;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_BURST = 2'd3
    } mode_t;

    // Registered state
    logic [PW-1:0]     presc_q;
    logic [N_LEDS-1:0] led_q;
    mode_t             mode_q  [N_LEDS];
    logic [5:0]        hp_q    [N_LEDS];
    logic [7:0]        cnt_q   [N_LEDS];
    logic [5:0]        phase_q [N_LEDS];

    // Next-state values
    logic [PW-1:0]     presc_d;
    logic [N_LEDS-1:0] led_d;
    mode_t             mode_d  [N_LEDS];
    logic [5:0]        hp_d    [N_LEDS];
    logic [7:0]        cnt_d   [N_LEDS];
    logic [5:0]        phase_d [N_LEDS];

    logic       wr_en;
    logic       cmd_wr;
    logic       all_off;
    logic       resync;
    logic       tick;
    logic [7:0] status;

    // Global decode: the command register sits at 0xF; all-off takes priority over resync.
    assign wr_en   = bus.cs & bus.wr;
    assign cmd_wr  = wr_en && (bus.addr == 4'hF);
    assign all_off = cmd_wr & bus.d_in[0];
    assign resync  = cmd_wr & bus.d_in[1] & ~bus.d_in[0];
    assign tick    = (presc_q == PW'(PRESC - 1));
    assign led     = led_q;

    // State register: prescaler, per-channel registers and LED bits.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            led_q   <= '0;
            // NOTE: these small register arrays have architected reset values, so every entry is reset explicitly.
            for (int c = 0; c < N_LEDS; c++) begin
                mode_q[c]  <= MODE_OFF;
                hp_q[c]    <= '0;
                cnt_q[c]   <= '0;
                phase_q[c] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            presc_q <= presc_d;
            led_q   <= led_d;
            for (int c = 0; c < N_LEDS; c++) begin
                mode_q[c]  <= mode_d[c];
                hp_q[c]    <= hp_d[c];
                cnt_q[c]   <= cnt_d[c];
                phase_q[c] <= phase_d[c];
            end
        end
    end

    // Next-state logic: priority is global command, then channel write, then tick.
    always_comb begin
        logic [5:0] hp_eff;
        logic       ctrl_wr;
        logic       cnt_wr;
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        hp_eff  = 6'd1;
        ctrl_wr = 1'b0;
        cnt_wr  = 1'b0;
        presc_d = (resync || tick) ? '0 : presc_q + PW'(1);
        led_d   = led_q;
        for (int c = 0; c < N_LEDS; c++) begin
            mode_d[c]  = mode_q[c];
            hp_d[c]    = hp_q[c];
            cnt_d[c]   = cnt_q[c];
            phase_d[c] = phase_q[c];
            hp_eff     = (hp_q[c] == 6'd0) ? 6'd1 : hp_q[c];
            ctrl_wr    = wr_en && (bus.addr == 4'(c));
            // CNT[7] would alias the command register when N_LEDS is 8; the command keeps 0xF.
            cnt_wr     = wr_en && (bus.addr == 4'(8 + c)) && (bus.addr != 4'hF);

            if (all_off) begin
                mode_d[c]  = MODE_OFF;
                phase_d[c] = '0;
                led_d[c]   = 1'b0;
            end else if (resync) begin
                phase_d[c] = '0;
                if (mode_q[c] == MODE_BLINK || mode_q[c] == MODE_BURST)
                    led_d[c] = 1'b1;
            end else if (ctrl_wr) begin
                mode_d[c]  = mode_t'(bus.d_in[1:0]);
                hp_d[c]    = bus.d_in[7:2];
                phase_d[c] = '0;
                led_d[c]   = (bus.d_in[1:0] != 2'd0);
                // A burst of zero blinks has nothing to do.
                if (bus.d_in[1:0] == 2'd3 && cnt_q[c] == 8'd0) begin
                    mode_d[c] = MODE_OFF;
                    led_d[c]  = 1'b0;
                end
            end else if (tick && (mode_q[c] == MODE_BLINK || mode_q[c] == MODE_BURST)) begin
                if (phase_q[c] + 6'd1 == hp_eff) begin
                    phase_d[c] = '0;
                    led_d[c]   = ~led_q[c];
                    // Bursts count falling toggles; a same-edge CNT write overrides this decrement.
                    if (mode_q[c] == MODE_BURST && led_q[c] && !cnt_wr) begin
                        if (cnt_q[c] <= 8'd1)
                            mode_d[c] = MODE_OFF;
                        cnt_d[c] = (cnt_q[c] == 8'd0) ? 8'd0 : cnt_q[c] - 8'd1;
                    end
                end else begin
                    phase_d[c] = phase_q[c] + 6'd1;
                end
            end

            if (cnt_wr)
                cnt_d[c] = bus.d_in;
        end
    end

    // Output logic: STATUS vector and the combinational read mux.
    always_comb begin
        status    = '0;
        bus.d_out = '0;
        for (int c = 0; c < N_LEDS; c++)
            status[c] = (mode_q[c] == MODE_BLINK) || (mode_q[c] == MODE_BURST);
        if (bus.cs && bus.rd) begin
            if (bus.addr == 4'hF) begin
                bus.d_out = status;
            end else begin
                for (int c = 0; c < N_LEDS; c++) begin
                    if (bus.addr == 4'(c))
                        bus.d_out = {hp_q[c], mode_q[c]};
                    else if (bus.addr == 4'(8 + c))
                        bus.d_out = cnt_q[c];
                end
            end
        end
    end

endmodule

// File: tb/tb_led_ctrl.sv
// tb_led_ctrl: scoreboard bench for led_ctrl with PRESC=4, N_LEDS=4.
// Expected values are queued when stimulus is applied and popped when the DUT is observed.
module tb_led_ctrl;

    localparam int N = 4;
    localparam int P = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] led;

    led_ctrl_if bus ();

    led_ctrl #(.N_LEDS(N), .PRESC(P)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .led (led)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    string      tag_q[$];
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic expect_val(input string tag, input logic [7:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic observe(input logic [7:0] got);
        string      t;
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            check("sb_underflow", 8'(exp_q.size()), 8'd1);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            check(t, got, e);
        end
    endtask

    // Drive at a rising edge so the falling edge in between captures the write.
    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        @(posedge clk);
        bus.addr = a;
        bus.d_in = d;
        bus.cs   = 1'b1;
        bus.wr   = 1'b1;
        @(posedge clk);
        bus.cs   = 1'b0;
        bus.wr   = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, input string tag, input logic [7:0] exp);
        expect_val(tag, exp);
        @(posedge clk);
        bus.addr = a;
        bus.cs   = 1'b1;
        bus.rd   = 1'b1;
        #1;
        observe(bus.d_out);
        bus.cs   = 1'b0;
        bus.rd   = 1'b0;
    endtask

    // Count rising edges until led[ch] leaves its current level, up to budget.
    task automatic measure(input int ch, input int budget, output int n);
        logic start;
        start = led[ch];
        n = 0;
        while (n < budget) begin
            @(posedge clk);
            n++;
            if (led[ch] != start) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        rst      = 1'b1;
        bus.addr = '0;
        bus.d_in = '0;
        bus.cs   = 1'b0;
        bus.rd   = 1'b0;
        bus.wr   = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        expect_val("reset_led", 8'h00);
        observe(8'(led));
        bus_read(4'h0, "reset_ctrl0", 8'h00);
        bus_read(4'hB, "reset_cnt3", 8'h00);
        bus_read(4'hF, "reset_status", 8'h00);

        // Reset mid-blink clears asynchronously
        bus_write(4'h0, 8'h06);
        expect_val("blink0_on", 8'h01);
        observe(8'(led));
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        expect_val("async_reset_led", 8'h00);
        observe(8'(led));
        #1 rst = 1'b0;
        bus_read(4'h0, "reset_ctrl0_after", 8'h00);

        // On / off, each on its write edge
        bus_write(4'h1, 8'h01);
        expect_val("on_led1", 8'h02);
        observe(8'(led));
        bus_write(4'h1, 8'h00);
        expect_val("off_led1", 8'h00);
        observe(8'(led));

        // Resync, ignored write to 0x4, then CTRL[2] lands on a tick edge: write wins
        bus_write(4'hF, 8'h02);
        bus_write(4'h4, 8'hFF);
        bus_write(4'h2, 8'h0A);
        expect_val("blink2_on", 8'h04);
        observe(8'(led));
        expect_val("blink2_first_high", 8'd8);
        measure(2, 40, n);
        observe(8'(n));
        expect_val("blink2_low", 8'd8);
        measure(2, 40, n);
        observe(8'(n));
        expect_val("blink2_high", 8'd8);
        measure(2, 40, n);
        observe(8'(n));
        bus_read(4'hF, "blink2_status", 8'h04);
        bus_read(4'h4, "ignored_addr4", 8'h00);
        bus_write(4'h2, 8'h00);

        // Burst of 3 with HP=1, aligned so the first pulse is a full tick period
        bus_write(4'hF, 8'h02);
        bus_write(4'hB, 8'd3);
        bus_write(4'h3, 8'h07);
        expect_val("burst_start", 8'h08);
        observe(8'(led));
        for (int k = 0; k < 3; k++) begin
            expect_val("burst_high", 8'd4);
            measure(3, 40, n);
            observe(8'(n));
            if (k < 2) begin
                expect_val("burst_gap", 8'd4);
                measure(3, 40, n);
                observe(8'(n));
            end
        end
        expect_val("burst_idle", 8'd20);
        measure(3, 20, n);
        observe(8'(n));
        bus_read(4'h3, "burst_ctrl3", 8'h04);
        bus_read(4'hB, "burst_cnt3", 8'h00);
        bus_read(4'hF, "burst_status", 8'h00);

        // Burst entered with CNT=0
        bus_write(4'h3, 8'h07);
        expect_val("burst_cnt0_led", 8'h00);
        observe(8'(led));
        bus_read(4'h3, "burst_cnt0_ctrl3", 8'h04);

        // Unmapped CNT slot
        bus_write(4'hC, 8'hFF);
        bus_read(4'hC, "ignored_addrC", 8'h00);

        // Global all-off during two active blinks
        bus_write(4'h0, 8'h06);
        bus_write(4'h1, 8'h0A);
        expect_val("two_blink_led1", 8'h01);
        observe(8'(led[1]));
        bus_read(4'hF, "two_blink_status", 8'h03);
        bus_write(4'hF, 8'h01);
        expect_val("all_off_led", 8'h00);
        observe(8'(led));
        bus_read(4'hF, "all_off_status", 8'h00);
        bus_read(4'h0, "all_off_ctrl0", 8'h04);
        bus_read(4'h1, "all_off_ctrl1", 8'h08);

        check("sb_drain", 8'(exp_q.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
